// File: rtl/config_chain_loader.sv
// Serialises parallel configuration words onto the fabric config chain,
// generating its own chain clock with stall, abort and completion signalling.
module config_chain_loader #(
  parameter int CHAIN_LEN   = 267,
  parameter int WORD_W      = 32,
  parameter int HALF_PERIOD = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [WORD_W-1:0]                word_in,
  input  logic                             word_valid,
  output logic                             word_ready,
  output logic                             config_in,
  output logic                             config_clk,
  output logic                             config_en,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(CHAIN_LEN+1)-1:0]   bits_sent
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(HALF_PERIOD - 1);
  localparam logic [WB_W-1:0]  LAST_WB  = WB_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOW,
    S_HIGH,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              bit_q, bit_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [WB_W-1:0]   wb_q, wb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_next;
  logic              ph_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= 1'b0;
      ph_q    <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sh_next = shift_q >> 1;
  assign ph_last = (ph_q == LAST_PH);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    wb_d    = wb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (word_valid) begin
          shift_d = word_in;
          bit_d   = word_in[0];
          wb_d    = '0;
          ph_d    = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (ph_last) begin
          ph_d    = '0;
          state_d = S_HIGH;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (ph_last) begin
          ph_d  = '0;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == LAST_CNT) begin
            state_d = S_FINISH;
            bit_d   = 1'b0;
          end else if (wb_q == LAST_WB) begin
            state_d = S_FETCH;
          end else begin
            // config_in only moves on entry to LOW, so the next bit is loaded here
            shift_d = sh_next;
            bit_d   = sh_next[0];
            wb_d    = wb_q + 1'b1;
            state_d = S_LOW;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // abort overrides the handshake; bits_sent keeps the edges already clocked
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      bit_d   = 1'b0;
      ph_d    = '0;
    end
  end

  assign word_ready = (state_q == S_FETCH);
  assign config_clk = (state_q == S_HIGH);
  assign config_en  = (state_q == S_FETCH) || (state_q == S_LOW) || (state_q == S_HIGH);
  assign busy       = config_en;
  assign done       = (state_q == S_FINISH);
  assign config_in  = bit_q;
  assign bits_sent  = cnt_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 267-bit chain instance and a 5-bit one,
// each checked against a chain model built from observed config_clk edges.
module tb_config_chain_loader;

  localparam int CL = 267;
  localparam int WW = 32;
  localparam int HP = 2;
  localparam int NW = (CL + WW - 1) / WW;
  localparam int LAT = CL * 2 * HP + NW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- large instance ----------------
  logic          rst = 1'b1, start = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [WW-1:0] word_in;
  logic          word_ready, cfg_in, cfg_clk, cfg_en, busy, done;
  logic [8:0]    bits_sent;
  logic [WW-1:0] words [16];
  int            widx = 0, wbase = 0;

  assign word_in = words[(widx - wbase) & 15];

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .HALF_PERIOD(HP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .config_in(cfg_in), .config_clk(cfg_clk), .config_en(cfg_en),
    .busy(busy), .done(done), .bits_sent(bits_sent));

  always @(posedge clk) if (word_valid && word_ready) widx <= widx + 1;

  // chain model: every rising config_clk shifts config_in in
  logic stream [8192];
  int   edges = 0, done_cnt = 0, stab_err = 0;
  logic prev_clk = 1'b0, hold_bit = 1'b0;
  always @(negedge clk) begin
    if (cfg_clk && !prev_clk) begin
      stream[edges & 8191] = cfg_in;
      hold_bit = cfg_in;
      edges++;
    end else if (cfg_clk && cfg_in !== hold_bit) begin
      stab_err++;
    end
    if (done) done_cnt++;
    prev_clk = cfg_clk;
  end

  // ---------------- small instance ----------------
  logic       s_start = 1'b0, s_valid = 1'b1;
  logic [3:0] s_word_in;
  logic       s_ready, s_cin, s_cclk, s_cen, s_busy, s_done;
  logic [2:0] s_bits;
  logic [3:0] s_words [4];
  int         s_widx = 0, s_edges = 0;
  logic       s_prev = 1'b0;
  logic [7:0] s_stream = '0;

  assign s_word_in = s_words[s_widx & 3];

  config_chain_loader #(.CHAIN_LEN(5), .WORD_W(4), .HALF_PERIOD(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .abort(1'b0),
    .word_in(s_word_in), .word_valid(s_valid), .word_ready(s_ready),
    .config_in(s_cin), .config_clk(s_cclk), .config_en(s_cen),
    .busy(s_busy), .done(s_done), .bits_sent(s_bits));

  always @(posedge clk) if (s_valid && s_ready) s_widx <= s_widx + 1;
  always @(negedge clk) begin
    if (s_cclk && !s_prev) begin
      if (s_edges < 8) s_stream[s_edges] = s_cin;
      s_edges++;
    end
    s_prev = s_cclk;
  end

  // ---------------- load helpers ----------------
  int base_e, base_d, cyc;

  task automatic begin_load();
    wbase  = widx;
    base_e = edges;
    base_d = done_cnt;
    word_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic finish_load(input string name, input int stall_word, input int stall_len);
    int sc, ovl, got_e;
    logic [CL-1:0] got, exp_img;
    logic [WW-1:0] w;
    sc = 0; ovl = 0;
    while (!done && cyc < 4000) begin
      if (word_ready && cfg_clk) ovl++;
      if (widx - wbase == stall_word && sc < stall_len) begin
        word_valid = 1'b0;
        if (word_ready) sc++;
      end else begin
        word_valid = 1'b1;
      end
      if (start) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done not seen after %0d cycles", name, cyc);
    end
    checks++;
    if (cyc !== LAT + stall_len) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, LAT + stall_len);
    end
    checks++;
    if (bits_sent !== 9'(CL)) begin
      errors++;
      $display("FAIL %s bits_sent: got %0d expected %0d", name, bits_sent, CL);
    end
    checks++;
    if (cfg_en !== 1'b0 || busy !== 1'b0 || cfg_clk !== 1'b0 || cfg_in !== 1'b0) begin
      errors++;
      $display("FAIL %s finish outputs: en=%b busy=%b clk=%b in=%b expected 0000",
               name, cfg_en, busy, cfg_clk, cfg_in);
    end
    repeat (3) @(negedge clk);
    got_e = edges - base_e;
    checks++;
    if (got_e !== CL) begin
      errors++;
      $display("FAIL %s edge count: got %0d expected %0d", name, got_e, CL);
    end
    checks++;
    if (done_cnt - base_d !== 1) begin
      errors++;
      $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt - base_d);
    end
    checks++;
    if (widx - wbase !== NW) begin
      errors++;
      $display("FAIL %s words consumed: got %0d expected %0d", name, widx - wbase, NW);
    end
    for (int i = 0; i < CL; i++) begin
      w = words[i / WW];
      exp_img[i] = w[i % WW];
      got[i] = stream[(base_e + i) & 8191];
    end
    checks++;
    if (got !== exp_img) begin
      errors++;
      $display("FAIL %s image: got %h expected %h", name, got, exp_img);
    end
    checks++;
    if (ovl !== 0 || stab_err !== 0) begin
      errors++;
      $display("FAIL %s stability: ready/clk overlap %0d, config_in changes while high %0d expected 0/0",
               name, ovl, stab_err);
    end
  endtask

  task automatic rand_words();
    for (int k = 0; k < 16; k++) words[k] = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({word_ready, cfg_in, cfg_clk, cfg_en, busy, done} !== 6'b0 || bits_sent !== 9'd0) begin
      errors++;
      $display("FAIL reset state: outs=%b bits_sent=%0d expected 000000/0",
               {word_ready, cfg_in, cfg_clk, cfg_en, busy, done}, bits_sent);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 16; k++) words[k] = '0;
    words[0] = 32'h0000_0005;
    begin_load();
    finish_load("basic", -1, 0);
  endtask

  task automatic test_stall();
    rand_words();
    begin_load();
    finish_load("stall", 3, 20);
  endtask

  task automatic test_abort();
    int t, e;
    rand_words();
    begin_load();
    t = 0;
    while (!(edges - base_e == 100 && !cfg_clk) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    e = edges - base_e;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (cfg_en !== 1'b0 || cfg_clk !== 1'b0 || busy !== 1'b0 || cfg_in !== 1'b0) begin
      errors++;
      $display("FAIL abort outputs: en=%b clk=%b busy=%b in=%b expected 0000",
               cfg_en, cfg_clk, busy, cfg_in);
    end
    checks++;
    if (bits_sent !== 9'(e) || e !== 100) begin
      errors++;
      $display("FAIL abort bits_sent: got %0d (edges %0d) expected 100", bits_sent, e);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== base_d || edges - base_e !== e) begin
      errors++;
      $display("FAIL abort quiet: done pulses %0d edges %0d expected 0 / %0d",
               done_cnt - base_d, edges - base_e, e);
    end
    rand_words();
    begin_load();
    finish_load("after_abort", -1, 0);
  endtask

  task automatic test_rst_mid();
    int t;
    rand_words();
    begin_load();
    t = 0;
    while (!(edges - base_e == 37 && cfg_clk) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({word_ready, cfg_in, cfg_clk, cfg_en, busy, done} !== 6'b0 || bits_sent !== 9'd0) begin
      errors++;
      $display("FAIL rst_mid outputs: outs=%b bits_sent=%0d expected 000000/0",
               {word_ready, cfg_in, cfg_clk, cfg_en, busy, done}, bits_sent);
    end
    rand_words();
    begin_load();
    checks++;
    if (busy !== 1'b1 || word_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart: busy=%b ready=%b expected 1/1", busy, word_ready);
    end
    finish_load("rst_restart", -1, 0);
  endtask

  task automatic test_back_to_back();
    int w0, bad;
    word_valid = 1'b1;
    w0 = widx;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (word_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || widx !== w0) begin
      errors++;
      $display("FAIL idle words: ready-high cycles %0d consumed %0d expected 0/0", bad, widx - w0);
    end
    rand_words();
    begin_load();
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    cyc = cyc + 241;
    start = 1'b1;
    // finish_load drops start on its first iteration
    finish_load("start_busy", -1, 0);
  endtask

  task automatic test_small();
    logic [7:0] cat;
    logic [4:0] exp_seq;
    int sc_cyc, w0, e0;
    s_words[0] = 4'hA; s_words[1] = 4'h1; s_words[2] = 4'hF; s_words[3] = 4'hF;
    cat = {s_words[1], s_words[0]};
    exp_seq = cat[4:0];
    w0 = s_widx; e0 = s_edges;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    sc_cyc = 1;
    while (!s_done && sc_cyc < 100) begin
      @(negedge clk);
      sc_cyc++;
    end
    checks++;
    if (sc_cyc !== 5 * 2 * 1 + 2 + 1) begin
      errors++;
      $display("FAIL small latency: got %0d expected 13", sc_cyc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (s_edges - e0 !== 5 || s_stream[4:0] !== exp_seq) begin
      errors++;
      $display("FAIL small sequence: edges %0d bits %b expected 5 / %b",
               s_edges - e0, s_stream[4:0], exp_seq);
    end
    checks++;
    if (s_widx - w0 !== 2 || s_bits !== 3'd5) begin
      errors++;
      $display("FAIL small words: consumed %0d bits_sent %0d expected 2/5", s_widx - w0, s_bits);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_basic();
    test_stall();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Transmit end of the fabric configuration chain.
- Accepts parallel configuration words from a host-side source over a valid/ready handshake.
- Serialises them onto the config_in / config_clk / config_en chain that feeds the CLB and switch-box shift registers.
- Generates the chain clock itself, so tile configuration happens in hardware, with stall, abort and completion signalling.

Parameters:
- CHAIN_LEN, 267, total configuration bits shifted per load (≥1).
- WORD_W, 32, width of each input word.
- HALF_PERIOD, 2, clk cycles per config_clk phase (low or high); ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  terminate the current load at the next clk edge.
- word_in  input  WORD_W  configuration word.
- word_valid  input  1  word_in valid.
- word_ready  output  1  loader accepts word_in this cycle.
- config_in  output  1  serial config bit to the chain.
- config_clk  output  1  chain shift clock; the chain samples on its rising edge.
- config_en  output  1  chain shift enable.
- busy  output  1  high from start acceptance until done/abort.
- done  output  1  one-cycle pulse after the last bit is clocked.
- bits_sent  output  $clog2(CHAIN_LEN+1)  count of completed config_clk rising edges in the current load.

Behaviour:
- Reset: state IDLE; word_ready, config_in, config_clk, config_en, busy and done all 0; bits_sent 0; shift word cleared. Reset mid-load forces the same; chain contents are then undefined and need a fresh load.
- Bit order:
  - Stream bit i = word_in bit (i mod WORD_W) of word number floor(i/WORD_W); word 0 goes first, LSB first.
  - Words per load = ceil(CHAIN_LEN/WORD_W).
  - Bits of the last word beyond CHAIN_LEN are discarded.
- State machine:
  - IDLE:
    - start → FETCH; busy=1, config_en=1, bits_sent=0.
    - start while not IDLE is ignored.
  - FETCH:
    - word_ready=1.
    - On word_valid&&word_ready, latch the word → LOW.
    - config_clk held 0 while waiting; this stalls the chain safely, with no edges.
  - LOW:
    - config_in = current bit, config_clk=0, held HALF_PERIOD cycles → HIGH.
    - config_in changes only on entry to LOW.
  - HIGH:
    - config_clk=1 for HALF_PERIOD cycles; config_in stable for the whole phase.
    - On exit, bits_sent increments. Then:
      - bits_sent==CHAIN_LEN → FINISH;
      - word exhausted → FETCH;
      - otherwise → LOW with the next bit.
  - FINISH (1 cycle):
    - config_clk=0, config_en=0, config_in=0, done=1, busy=0 → IDLE.
    - bits_sent holds its final value until the next start.
- Timing:
  - Each bit takes exactly 2*HALF_PERIOD cycles.
  - With word_valid held high, an unstalled load is CHAIN_LEN*2*HALF_PERIOD + ceil(CHAIN_LEN/WORD_W) + 1 cycles from the start edge to the done pulse.
- Abort:
  - From any non-IDLE state → IDLE next cycle.
  - config_clk/config_en/config_in driven 0; no done pulse; busy=0. A word being accepted that cycle is dropped.
  - Abort has priority over the handshake and over start.
- Simultaneous rst and abort: reset wins; the result is identical.
- word_ready is never high outside FETCH. Words presented outside FETCH are not consumed.
- At most one config_clk rising edge per bit; never more than CHAIN_LEN edges per load.

Test Plan:
- CHAIN_LEN=267, WORD_W=32, HALF_PERIOD=2; feed 9 words with word 0 = 32'h0000_0005 and the rest 0; model the chain as a 267-bit shift register → exactly 267 rising edges, model bit0=1, bit1=0, bit2=1, all others 0; done pulses once; bits_sent=267; done arrives 1078 cycles after start with valid held high.
- Random 9-word payload with word_valid deasserted for 20 cycles before word 3 → config_clk stays 0 during the stall; final shifted image equals the payload's low 267 bits; the top 21 bits of word 8 are never driven.
- Abort asserted after 100 config_clk edges → next cycle config_en=0, config_clk=0, busy=0, no done pulse, bits_sent=100; a following start performs a full clean load.
- rst asserted during a HIGH phase → next cycle all outputs 0 and state IDLE; start is accepted the cycle after rst falls.
- start pulsed while busy, and words offered while in IDLE → no effect; word_ready stays 0; edge count unchanged.
- CHAIN_LEN=5, WORD_W=4, HALF_PERIOD=1, words 4'hA then 4'h1 → serial sequence 0,1,0,1,1; exactly 2 words consumed; done arrives 13 cycles after start.
